mmu_result_accumulator: RTL
===========================

// Module: mmu_result_accumulator
// PURPOSE
//  Downstream stage of the matrix multiply unit. Consumes its per-cycle signed 32-bit partial
//  dot products, sums a job of LEN beats in a wide accumulator, clamps to OUT_W signed, and
//  queues results in a small output FIFO for the writeback stage. One job is in flight at a time.
// PARAMETERS
//  DATA_W      32  width of incoming partial products (signed two's complement)
//  LEN_W       16  width of job length field (max 2^LEN_W-1 beats)
//  ACC_W       48  accumulator width; must be >= DATA_W+LEN_W so the sum never wraps
//  OUT_W       32  width of emitted result after signed saturation
//  FIFO_DEPTH  4   output FIFO entries (power of two, >= 2)
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       single-cycle job start; sampled only in IDLE
//  len        in   LEN_W   beats in the job, sampled with start
//  busy       out  1       high whenever state != IDLE
//  err_len    out  1       one-cycle pulse: start seen in IDLE with len == 0
//  in_valid   in   1       partial product valid
//  in_ready   out  1       accumulator can take a beat (high only in ACCUM)
//  in_data    in   DATA_W  signed partial product
//  out_valid  out  1       FIFO not empty
//  out_ready  in   1       consumer accepts head entry
//  out_data   out  OUT_W   head entry: saturated result
//  out_sat    out  1       head entry: 1 if the result was clamped
// BEHAVIOUR
//  Reset (async, any time incl. mid-job): state=IDLE, acc=0, count=0, FIFO emptied;
//   busy=0, err_len=0, in_ready=0, out_valid=0, out_data=0, out_sat=0. Partial job discarded.
//  States: IDLE -> ACCUM -> PUSH -> IDLE.
//   IDLE : start && len!=0 -> ACCUM, acc<=0, count<=len. start && len==0 -> stay IDLE,
//          err_len=1 in the following cycle only. start outside IDLE is ignored (no error).
//   ACCUM: in_ready=1. Beat accepted when in_valid && in_ready:
//          acc <= acc + sign_extend(in_data, ACC_W); count <= count-1.
//          Accepted beat with count==1 -> PUSH. in_valid low stalls, no timeout.
//   PUSH : in_ready=0. Entry written when FIFO has room (see below) -> IDLE; else hold in PUSH.
//  Saturation: acc > 2^(OUT_W-1)-1 -> out 2^(OUT_W-1)-1, sat=1; acc < -2^(OUT_W-1) ->
//   out -2^(OUT_W-1), sat=1; otherwise out = acc[OUT_W-1:0], sat=0.
//  Latency: last beat accepted at cycle t -> PUSH in t+1 -> out_valid high at t+2 (FIFO empty).
//   Earliest next start is sampled in t+2 (IDLE); back-to-back jobs cost 2 idle input cycles.
//  FIFO: first-word-fall-through; out_data/out_sat show head combinationally from storage;
//   pop on out_valid && out_ready. Push allowed when not full, OR when full and a pop occurs in
//   the same cycle (simultaneous push+pop on full keeps occupancy at FIFO_DEPTH).
//   Simultaneous push+pop when empty is impossible (push only from PUSH; out_valid=0).
//   Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
//  out_data/out_sat are 0 when FIFO empty. Order of results equals order of job completion.
// TESTING
//  1 len=4, beats 1,2,3,4, out_ready=1 -> out_data=10, out_sat=0, out_valid 2 cycles after beat 4.
//  2 len=3, beats 0xFFFFFFFF x3 -> out_data=0xFFFFFFFD (-3), out_sat=0; in_valid gaps don't change it.
//  3 len=3, 0x7FFFFFFF x3 -> 0x7FFFFFFF, sat=1; len=2, 0x80000000 x2 -> 0x80000000, sat=1;
//    len=2, 0x7FFFFFFF,0x80000000 -> 0xFFFFFFFF, sat=0.
//  4 out_ready=0, five len=1 jobs (values 1..5): 4 queue, 5th holds PUSH with busy=1, in_ready=0;
//    raise out_ready -> outputs 1,2,3,4,5 in order, push of 5 lands on the full-pop cycle.
//  5 start len=0 in IDLE -> err_len one cycle, busy stays 0; start len=9 during ACCUM -> ignored,
//    original job length honoured.
//  6 assert rst after 2 of 4 beats -> all outputs 0 immediately, FIFO empty; new len=1 job of 7 -> 7.

Source files
------------

// File: rtl/mmu_result_accumulator_if.sv
// Handshake bundle between the MMU partial-product stream, the job controller and writeback.
// master drives jobs/beats and consumes results; slave is the accumulator.
interface mmu_result_accumulator_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int OUT_W  = 32
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              err_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  busy, err_len, in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output busy, err_len, in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mmu_result_accumulator.sv
// Sums a job of LEN signed partial products into a wide accumulator, saturates to OUT_W
// and queues the result in a first-word-fall-through FIFO for writeback.
module mmu_result_accumulator #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int ACC_W      = 48,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  mmu_result_accumulator_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_PUSH  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [LEN_W-1:0]        count_reg, count_next;
  logic                    err_len_reg, err_len_next;

  logic signed [ACC_W-1:0] beat_ext;
  logic                    beat_fire;
  logic                    push_en;
  logic                    pop_en;

  logic                    acc_fits;
  logic [OUT_W-1:0]        sat_data;
  logic                    sat_flag;

  logic [OUT_W-1:0]        data_mem [FIFO_DEPTH];
  logic                    sat_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]          occ_reg;
  logic                    fifo_empty;
  logic                    fifo_full;

  assign beat_ext   = {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
  assign beat_fire  = (state_reg == ST_ACCUM) && bus.in_valid;
  assign fifo_empty = (occ_reg == '0);
  assign fifo_full  = (occ_reg == OCC_FULL);
  assign pop_en     = !fifo_empty && bus.out_ready;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push_en    = (state_reg == ST_PUSH) && (!fifo_full || pop_en);

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    count_next   = count_reg;
    err_len_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            err_len_next = 1'b1;
          end else begin
            state_next = ST_ACCUM;
            acc_next   = '0;
            count_next = bus.len;
          end
        end
      end
      ST_ACCUM: begin
        if (beat_fire) begin
          acc_next   = acc_reg + beat_ext;
          count_next = count_reg - LEN_W'(1);
          if (count_reg == LEN_W'(1)) begin
            state_next = ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        if (push_en) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      acc_reg     <= '0;
      count_reg   <= '0;
      err_len_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      count_reg   <= count_next;
      err_len_reg <= err_len_next;
    end
  end

  // The sum fits when every bit above the OUT_W sign bit matches that sign bit.
  assign acc_fits = (acc_reg[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){acc_reg[OUT_W-1]}});

  always_comb begin
    sat_data = acc_reg[OUT_W-1:0];
    sat_flag = 1'b0;
    if (!acc_fits) begin
      sat_flag = 1'b1;
      if (acc_reg[ACC_W-1]) begin
        sat_data = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        sat_data = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      data_mem[wr_ptr_reg] <= sat_data;
      sat_mem[wr_ptr_reg]  <= sat_flag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   occ_reg <= occ_reg + (PTR_W+1)'(1);
        2'b01:   occ_reg <= occ_reg - (PTR_W+1)'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.in_ready  = (state_reg == ST_ACCUM);
  assign bus.err_len   = err_len_reg;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : data_mem[rd_ptr_reg];
  assign bus.out_sat   = fifo_empty ? 1'b0 : sat_mem[rd_ptr_reg];
endmodule
